// File: rtl/fifo_arb_pkg.sv
`default_nettype none
// ==========================================================================
// fifo_arb_pkg - state encoding and defaults for fifo_wr_arbiter. Rev 1.0
// ==========================================================================
package fifo_arb_pkg;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_SEND = 1'b1
  } arb_state_e;

  localparam int DEF_DATA_WIDTH = 8;
  localparam int DEF_NUM_REQ    = 2;
  localparam int DEF_MAX_BYTES  = 2;
  localparam int DEF_LEN_WIDTH  = 2;

  localparam int                 STALL_W   = 16;
  localparam logic [STALL_W-1:0] STALL_SAT = 16'hFFFF;

  // Index width that stays legal when only one entry exists
  function automatic int idx_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage
`default_nettype wire

// File: rtl/rr_arbiter.sv
`default_nettype none
// ==========================================================================
// rr_arbiter - combinational round-robin pick starting after last_grant. Rev 1.0
// ==========================================================================
module rr_arbiter
  import fifo_arb_pkg::*;
#(
  parameter int NUM_REQ = DEF_NUM_REQ,
  parameter int IDX_W   = idx_width(NUM_REQ)
) (
  input  logic [NUM_REQ-1:0] req_i,
  input  logic [IDX_W-1:0]   last_grant_i,
  output logic [NUM_REQ-1:0] grant_o,
  output logic [IDX_W-1:0]   grant_idx_o,
  output logic               grant_vld_o
);

  int               cand;
  logic [IDX_W-1:0] cand_idx;

  always_comb begin
    grant_o     = '0;
    grant_idx_o = '0;
    grant_vld_o = 1'b0;
    cand        = 0;
    cand_idx    = '0;
    for (int off = 1; off <= NUM_REQ; off++) begin
      cand     = (int'(last_grant_i) + off) % NUM_REQ;
      cand_idx = IDX_W'(cand);
      if (!grant_vld_o && req_i[cand_idx]) begin
        grant_vld_o       = 1'b1;
        grant_o[cand_idx] = 1'b1;
        grant_idx_o       = cand_idx;
      end
    end
  end

endmodule
`default_nettype wire

// File: rtl/fifo_wr_arbiter.sv
`default_nettype none
// ==========================================================================
// fifo_wr_arbiter - round-robin frame writer onto one FIFO write port; stall
// statistic built only with FIFO_WR_ARB_STATS_EN defined. Rev 1.0
// ==========================================================================
module fifo_wr_arbiter
  import fifo_arb_pkg::*;
#(
  parameter int DATA_WIDTH = DEF_DATA_WIDTH,
  parameter int NUM_REQ    = DEF_NUM_REQ,
  parameter int MAX_BYTES  = DEF_MAX_BYTES,
  parameter int LEN_WIDTH  = DEF_LEN_WIDTH
) (
  input  logic                                  wclk,
  input  logic                                  wrst_n,
  input  logic [NUM_REQ-1:0]                    req,
  input  logic [NUM_REQ*MAX_BYTES*DATA_WIDTH-1:0] req_data,
  input  logic [NUM_REQ*LEN_WIDTH-1:0]          req_len,
  output logic [NUM_REQ-1:0]                    ack,
  input  logic                                  wfull,
  output logic                                  winc,
  output logic [DATA_WIDTH-1:0]                 wdata,
  output logic                                  busy,
  output logic [15:0]                           stall_cnt
);

  localparam int                   IDX_W   = idx_width(NUM_REQ);
  localparam int                   BYTE_W  = idx_width(MAX_BYTES);
  localparam int                   FRAME_W = MAX_BYTES * DATA_WIDTH;
  localparam logic [LEN_WIDTH-1:0] LEN_MAX = LEN_WIDTH'(MAX_BYTES);

  arb_state_e            state_q, state_d;
  logic [IDX_W-1:0]      last_q, last_d;
  logic [NUM_REQ-1:0]    ack_q, ack_d;
  logic [FRAME_W-1:0]    frame_q, frame_d;
  logic [LEN_WIDTH-1:0]  len_q, len_d;
  logic [BYTE_W-1:0]     idx_q, idx_d;
  logic [DATA_WIDTH-1:0] wdata_q, wdata_d;
  logic                  winc_w;

  logic [NUM_REQ-1:0]    gnt_oh;
  logic [IDX_W-1:0]      gnt_idx;
  logic                  gnt_vld;

  logic [FRAME_W-1:0]    slot_data [NUM_REQ];
  logic [LEN_WIDTH-1:0]  slot_len  [NUM_REQ];
  logic [DATA_WIDTH-1:0] frame_byte [MAX_BYTES];
  logic [FRAME_W-1:0]    sel_data;
  logic [LEN_WIDTH-1:0]  sel_len;
  logic [LEN_WIDTH-1:0]  sel_len_c;

  for (genvar i = 0; i < NUM_REQ; i++) begin : g_slot
    assign slot_data[i] = req_data[i*FRAME_W +: FRAME_W];
    assign slot_len[i]  = req_len[i*LEN_WIDTH +: LEN_WIDTH];
  end

  for (genvar b = 0; b < MAX_BYTES; b++) begin : g_byte
    assign frame_byte[b] = frame_q[b*DATA_WIDTH +: DATA_WIDTH];
  end

  rr_arbiter #(
    .NUM_REQ (NUM_REQ),
    .IDX_W   (IDX_W)
  ) u_rr (
    .req_i        (req),
    .last_grant_i (last_q),
    .grant_o      (gnt_oh),
    .grant_idx_o  (gnt_idx),
    .grant_vld_o  (gnt_vld)
  );

  assign sel_data  = slot_data[gnt_idx];
  assign sel_len   = slot_len[gnt_idx];
  assign sel_len_c = (sel_len > LEN_MAX) ? LEN_MAX : sel_len;

  always_comb begin
    state_d = state_q;
    last_d  = last_q;
    ack_d   = '0;
    frame_d = frame_q;
    len_d   = len_q;
    idx_d   = idx_q;
    wdata_d = wdata_q;
    winc_w  = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (gnt_vld) begin
          ack_d   = gnt_oh;
          last_d  = gnt_idx;
          frame_d = sel_data;
          len_d   = sel_len_c;
          idx_d   = '0;
          // Empty frames are acked but never touch the write port or wdata
          if (sel_len_c != '0) begin
            state_d = ST_SEND;
            wdata_d = sel_data[DATA_WIDTH-1:0];
          end
        end
      end
      ST_SEND: begin
        winc_w = !wfull;
        if (winc_w) begin
          if (idx_q == BYTE_W'(len_q - LEN_WIDTH'(1))) begin
            state_d = ST_IDLE;
            idx_d   = '0;
          end else begin
            idx_d   = idx_q + BYTE_W'(1);
            wdata_d = frame_byte[idx_q + BYTE_W'(1)];
          end
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge wclk or negedge wrst_n) begin
    if (!wrst_n) begin
      state_q <= ST_IDLE;
      last_q  <= IDX_W'(NUM_REQ - 1);
      ack_q   <= '0;
      frame_q <= '0;
      len_q   <= '0;
      idx_q   <= '0;
      wdata_q <= '0;
    end else begin
      state_q <= state_d;
      last_q  <= last_d;
      ack_q   <= ack_d;
      frame_q <= frame_d;
      len_q   <= len_d;
      idx_q   <= idx_d;
      wdata_q <= wdata_d;
    end
  end

  assign ack   = ack_q;
  assign winc  = winc_w;
  assign wdata = wdata_q;
  assign busy  = (state_q == ST_SEND);

`ifdef FIFO_WR_ARB_STATS_EN
  logic [STALL_W-1:0] stall_q;

  always_ff @(posedge wclk or negedge wrst_n) begin
    if (!wrst_n) begin
      stall_q <= '0;
    end else if (state_q == ST_SEND && wfull && stall_q != STALL_SAT) begin
      stall_q <= stall_q + STALL_W'(1);
    end
  end

  assign stall_cnt = stall_q;
`else
  assign stall_cnt = '0;
`endif

endmodule
`default_nettype wire
